// File: rtl/prio_encoder_4to2.sv
// rtl/prio_encoder_4to2.sv - registered highest-set-bit priority encoder
module prio_encoder_4to2 #(
  parameter int IN_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic [$clog2(IN_WIDTH)-1:0]   out_data,
  output logic                          out_valid
);

  localparam int OUT_WIDTH = $clog2(IN_WIDTH);

  logic [OUT_WIDTH-1:0] w_idx;
  logic                 w_any_set;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;

  // Ascending scan: a later (higher) set bit overwrites earlier ones, so the MSB wins.
  always_comb begin
    w_idx     = '0;
    w_any_set = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (in_data[i]) begin
        w_idx     = OUT_WIDTH'(i);
        w_any_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= w_idx;
      r_out_valid <= w_any_set;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_prio_encoder_4to2.sv
// tb/tb_prio_encoder_4to2.sv - self-checking bench for prio_encoder_4to2 (4- and 8-bit)
`timescale 1ns/1ps
module tb_prio_encoder_4to2;

  logic       clk;
  logic       reset;
  logic [3:0] in_data;
  logic [1:0] out_data;
  logic       out_valid;
  logic [7:0] in_data8;
  logic [2:0] out_data8;
  logic       out_valid8;

  int errors;
  int checks;

  prio_encoder_4to2 encoder (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  prio_encoder_4to2 #(.IN_WIDTH(8)) encoder8 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data8),
    .out_data  (out_data8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [1:0] exp_data;
    logic       exp_valid;
  } vec_t;

  // Reference: index of the highest set bit is floor(log2(v)) = clog2(v+1)-1.
  function automatic int ref_idx(input int v);
    if (v == 0) return 0;
    return $clog2(v + 1) - 1;
  endfunction

  task automatic check(input string name, input int act_d, input int exp_d,
                       input int act_v, input int exp_v);
    checks++;
    if (act_d !== exp_d || act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got data=%0d valid=%0d, expected data=%0d valid=%0d",
               name, act_d, act_v, exp_d, exp_v);
    end
  endtask

  // Drive at the falling edge, let one rising edge capture, sample at the next falling edge.
  task automatic step(input logic [3:0] d4, input logic [7:0] d8);
    in_data  = d4;
    in_data8 = d8;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0] r4;
    logic [7:0] r8;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    in_data  = 4'b1000;
    in_data8 = 8'hFF;

    vecs.push_back('{4'b0001, 2'd0, 1'b1});
    vecs.push_back('{4'b0010, 2'd1, 1'b1});
    vecs.push_back('{4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b1000, 2'd3, 1'b1});
    vecs.push_back('{4'b0110, 2'd2, 1'b1});
    vecs.push_back('{4'b1111, 2'd3, 1'b1});
    vecs.push_back('{4'b0011, 2'd1, 1'b1});
    vecs.push_back('{4'b0101, 2'd2, 1'b1});
    vecs.push_back('{4'b1001, 2'd3, 1'b1});
    vecs.push_back('{4'b0000, 2'd0, 1'b0});
    vecs.push_back('{4'b0001, 2'd0, 1'b1});

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 8'hFF);
      check("reset_hold", out_data, 0, out_valid, 0);
      check("reset_hold8", out_data8, 0, out_valid8, 0);
    end
    reset = 1'b0;
    step(4'b1000, 8'b0010_0100);
    check("release", out_data, 3, out_valid, 1);
    check("release8", out_data8, 5, out_valid8, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in, 8'h00);
      check($sformatf("vec%0d", i), out_data, vecs[i].exp_data,
            out_valid, vecs[i].exp_valid);
    end
    check("zero8", out_data8, 0, out_valid8, 0);

    // Outputs must hold across a full cycle once inputs change but no edge has occurred.
    step(4'b0100, 8'h80);
    in_data = 4'b0001;
    #3;
    check("hold", out_data, 2, out_valid, 1);
    check("hold8", out_data8, 7, out_valid8, 1);
    @(negedge clk);

    // Reset mid-stream for one edge.
    for (int i = 0; i < 5; i++) begin
      r4 = 4'($urandom);
      r8 = 8'($urandom);
      step(r4, r8);
      check("stream", out_data, ref_idx(r4), out_valid, int'(r4 != 0));
    end
    reset = 1'b1;
    step(4'b1100, 8'h11);
    check("mid_reset", out_data, 0, out_valid, 0);
    check("mid_reset8", out_data8, 0, out_valid8, 0);
    reset = 1'b0;
    step(4'b0110, 8'h11);
    check("after_reset", out_data, 2, out_valid, 1);
    check("after_reset8", out_data8, 4, out_valid8, 1);

    for (int i = 0; i < 1000; i++) begin
      r4 = 4'($urandom);
      r8 = 8'($urandom);
      step(r4, r8);
      check("rand4", out_data, ref_idx(r4), out_valid, int'(r4 != 0));
      check("rand8", out_data8, ref_idx(r8), out_valid8, int'(r8 != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
